// File: rtl/adder_dft_pkg.sv
// ---------------------------------------------------------------------------
// adder_dft_pkg
// Shared definitions for the adder DFT blocks (input-side test-mode mux and
// output-side scan observation).
//   ADDER_W       : default adder data width
//   scan_state_t  : observation FSM states (ST_IDLE, ST_SHIFT, ST_DONE)
//   cnt_width()   : width of a counter able to hold values 0 .. n-1
// ---------------------------------------------------------------------------
package adder_dft_pkg;

    localparam int ADDER_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } scan_state_t;

    // Never return zero, so a degenerate width still gives a legal vector.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// ---------------------------------------------------------------------------
// scan_shift_reg
// Generic capture/shift register for a scan segment: parallel load, then
// serial shift toward bit 0 with enable. Serial data enters at the MSB.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset (clears the register)
//   load      in   parallel load of load_data (wins over shift_en)
//   load_data in   [W-1:0] data to capture
//   shift_en  in   shift right by one, scan_in into bit W-1
//   scan_in   in   serial input
//   ser_out   out  current bit 0 of the register
// ---------------------------------------------------------------------------
module scan_shift_reg #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         shift_en,
    input  logic         scan_in,
    output logic         ser_out
);

    logic [W-1:0] sreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= load_data;
        end else if (shift_en) begin
            sreg <= {scan_in, sreg[W-1:1]};
        end
    end

    assign ser_out = sreg[0];

endmodule

// File: rtl/adder_scan_observe.sv
// ---------------------------------------------------------------------------
// adder_scan_observe
// Observation-side DFT block for the N-bit adder. On start (in IDLE) it
// captures {cout, sum} and shifts it out LSB first on scan_out, one bit per
// unstalled cycle, then pulses done. scan_in daisy-chains a downstream
// segment into the MSB of the shift register.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset, highest priority
//   sum        in   [N-1:0] adder sum to observe
//   cout       in   adder carry-out to observe
//   start      in   capture request, honoured only in IDLE
//   stall      in   freezes shifting while high
//   scan_in    in   serial data into the shift register MSB
//   scan_out   out  serial data (sum[0] first, cout last); 0 when not valid
//   scan_valid out  scan_out carries a captured bit
//   busy       out  high in SHIFT and DONE
//   done       out  one-cycle pulse after the last bit
// ---------------------------------------------------------------------------
module adder_scan_observe
    import adder_dft_pkg::*;
#(
    parameter int N     = ADDER_W,
    parameter int CNT_W = cnt_width(N + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sum,
    input  logic         cout,
    input  logic         start,
    input  logic         stall,
    input  logic         scan_in,
    output logic         scan_out,
    output logic         scan_valid,
    output logic         busy,
    output logic         done
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N);

    scan_state_t      state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic             load, shift_en, sreg_out;

    scan_shift_reg #(
        .W (N + 1)
    ) u_sreg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data ({cout, sum}),
        .shift_en  (shift_en),
        .scan_in   (scan_in),
        .ser_out   (sreg_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Next-state and outputs. The counter saturates at N on the final shift
    // so it never leaves the 0..N range.
    always_comb begin
        state_next = state;
        count_next = count;
        load       = 1'b0;
        shift_en   = 1'b0;
        scan_out   = 1'b0;
        scan_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    count_next = '0;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                scan_out   = sreg_out;
                scan_valid = 1'b1;
                busy       = 1'b1;
                if (!stall) begin
                    shift_en = 1'b1;
                    if (count == LAST_BIT) begin
                        state_next = ST_DONE;
                    end else begin
                        count_next = count + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_adder_scan_observe.sv
// ---------------------------------------------------------------------------
// tb_adder_scan_observe
// Directed self-checking bench for adder_scan_observe (N = 16).
// ---------------------------------------------------------------------------
module tb_adder_scan_observe;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sum;
    logic        cout;
    logic        start;
    logic        stall;
    logic        scan_in;
    logic        scan_out;
    logic        scan_valid;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    adder_scan_observe #(.N(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .sum        (sum),
        .cout       (cout),
        .start      (start),
        .stall      (stall),
        .scan_in    (scan_in),
        .scan_out   (scan_out),
        .scan_valid (scan_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Present a capture request for exactly one edge.
    task automatic applyStimulus(input logic [15:0] s, input logic c);
        sum   = s;
        cout  = c;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " busy"},     32'(busy),       32'd0);
        checkOutput({tag, " done"},     32'(done),       32'd0);
        checkOutput({tag, " valid"},    32'(scan_valid), 32'd0);
        checkOutput({tag, " scan_out"}, 32'(scan_out),   32'd0);
    endtask

    // One full capture. stall_at/start_at/rst_at name the bit index after
    // which the disturbance is applied; -1 disables it.
    task automatic runCapture(input string tag, input logic [15:0] s, input logic c,
                              input logic [16:0] expected,
                              input int stall_at, input int stall_len,
                              input int start_at, input int rst_at);
        string t;
        applyStimulus(s, c);
        for (int i = 0; i <= 16; i++) begin
            t = $sformatf("%s bit%0d", tag, i);
            checkOutput({t, " valid"},    32'(scan_valid), 32'd1);
            checkOutput({t, " scan_out"}, 32'(scan_out),   32'(expected[i]));
            checkOutput({t, " busy"},     32'(busy),       32'd1);
            checkOutput({t, " done"},     32'(done),       32'd0);
            if (i == rst_at) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                checkIdle({tag, " after reset"});
                checkOutput({tag, " sreg cleared"}, 32'(dut.u_sreg.sreg), 32'd0);
                step();
                checkIdle({tag, " post reset"});
                return;
            end
            if (i == stall_at) begin
                stall = 1'b1;
                for (int k = 0; k < stall_len; k++) begin
                    step();
                    checkOutput({t, " stall valid"}, 32'(scan_valid), 32'd1);
                    checkOutput({t, " stall hold"},  32'(scan_out),   32'(expected[i]));
                    checkOutput({t, " stall done"},  32'(done),       32'd0);
                end
                stall = 1'b0;
            end
            if (i == start_at) begin
                start = 1'b1;
                sum   = 16'h0000;
                cout  = 1'b0;
            end
            step();
            start = 1'b0;
        end
        checkOutput({tag, " done pulse"}, 32'(done),       32'd1);
        checkOutput({tag, " done busy"},  32'(busy),       32'd1);
        checkOutput({tag, " done valid"}, 32'(scan_valid), 32'd0);
        checkOutput({tag, " done out"},   32'(scan_out),   32'd0);
        step();
        checkIdle({tag, " idle"});
    endtask

    initial begin
        rst     = 1'b1;
        sum     = '0;
        cout    = 1'b0;
        start   = 1'b0;
        stall   = 1'b0;
        scan_in = 1'b0;
        step();
        step();
        rst = 1'b0;
        checkIdle("reset");
        checkOutput("reset sreg", 32'(dut.u_sreg.sreg), 32'd0);

        // start low keeps the block idle
        step();
        checkIdle("no start");

        runCapture("ones",  16'hFFFF, 1'b1, 17'h1FFFF, -1, 0, -1, -1);
        runCapture("lsb",   16'h0001, 1'b0, 17'h00001, -1, 0, -1, -1);
        runCapture("msb",   16'h0000, 1'b1, 17'h10000, -1, 0, -1, -1);
        runCapture("stall", 16'hA5A5, 1'b0, 17'h0A5A5,  4, 3, -1, -1);
        runCapture("ignst", 16'h1234, 1'b1, 17'h11234, -1, 0,  5, -1);
        // accepted immediately in the IDLE cycle after DONE
        runCapture("turn",  16'h8001, 1'b0, 17'h08001, -1, 0, -1, -1);
        runCapture("rstmid", 16'hC3C3, 1'b1, 17'h1C3C3, -1, 0, -1,  7);
        runCapture("fresh", 16'h5A0F, 1'b0, 17'h05A0F, -1, 0, -1, -1);

        scan_in = 1'b1;
        runCapture("chain", 16'h0000, 1'b0, 17'h00000, -1, 0, -1, -1);
        checkOutput("chain sreg", 32'(dut.u_sreg.sreg), 32'h1FFFF);
        scan_in = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
